// File: rtl/led_code_sequencer.sv
// -----------------------------------------------------------------------------
// led_code_sequencer
//
// Several requesters share the single board status LED through this block.
// Each requester asks for an N-pulse blink code, and a fixed-priority arbiter
// picks the lowest active index. A tick-driven FSM then plays the pulses:
// N x (ON_TICKS lit, OFF_TICKS dark between pulses) followed by GAP_TICKS
// dark. While nothing is pending, the LED can show a heartbeat instead.
//
// Ports
//   CLK        system clock
//   RESET      asynchronous, active-high reset
//   REQ        [NREQ]    level request, bit i = requester i
//   CODE       [4*NREQ]  pulse count of requester i in bits [4i+3:4i] (0..15)
//   HB_EN      enable heartbeat blinking while idle
//   GRANT      [NREQ]    one-hot owner of the LED, all zero while idle
//   BUSY       high whenever a code is in progress (state != IDLE)
//   DONE       one-cycle pulse on the edge a granted code finishes
//   LED        LED drive, 1 = lit
//   DBG_STATE  [2]       current FSM state (0 IDLE, 1 ON, 2 OFF, 3 GAP)
//
// Request/grant handshake: requester i holds REQ[i] high, with CODE[i]
// stable, until GRANT[i] rises. CODE[i] is captured on that grant edge, and
// from then on REQ/CODE are ignored until the code ends. DONE pulses on the
// edge where GRANT falls. If REQ is still high after that edge, it counts as
// a fresh request and is arbitrated on the following edge, so at least one
// IDLE cycle always separates two codes. A code cannot be aborted; only
// RESET stops it, and in that case no DONE is issued.
//
// Parameter constraints: CLKFREQ/TICK_HZ is an integer >= 2,
// NREQ is 1..8, and all *_TICKS parameters are >= 1.
// -----------------------------------------------------------------------------
module led_code_sequencer #(
   parameter int CLKFREQ   = 25000000,
   parameter int TICK_HZ   = 10,
   parameter int NREQ      = 4,
   parameter int ON_TICKS  = 2,
   parameter int OFF_TICKS = 3,
   parameter int GAP_TICKS = 10,
   parameter int HB_TICKS  = 5
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [NREQ-1:0]   REQ,
   input  logic [4*NREQ-1:0] CODE,
   input  logic              HB_EN,
   output logic [NREQ-1:0]   GRANT,
   output logic              BUSY,
   output logic              DONE,
   output logic              LED,
   output logic [1:0]        DBG_STATE
);

   // ---------------------------------------------------------------------------
   // Derived constants
   // ---------------------------------------------------------------------------
   localparam int TICKDIV = CLKFREQ / TICK_HZ;
   localparam int PW      = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;

   // The phase counter is shared by ON/OFF/GAP. The heartbeat counter uses the
   // same width, so size both for the longest interval of the four.
   localparam int MAX_A   = (ON_TICKS  > OFF_TICKS) ? ON_TICKS  : OFF_TICKS;
   localparam int MAX_B   = (GAP_TICKS > HB_TICKS)  ? GAP_TICKS : HB_TICKS;
   localparam int MAXT    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = (MAXT > 1) ? $clog2(MAXT + 1) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKDIV - 1);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
   localparam logic [CW-1:0] ON_LAST    = CW'(ON_TICKS - 1);
   localparam logic [CW-1:0] OFF_LAST   = CW'(OFF_TICKS - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_TICKS - 1);
   localparam logic [CW-1:0] HB_LAST    = CW'(HB_TICKS - 1);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ON   = 2'd1,
      S_OFF  = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Signals
   // ---------------------------------------------------------------------------
   state_t            state_q;
   state_t            state_d;

   logic [PW-1:0]     presc_q;
   logic              tick;

   logic [CW-1:0]     phase_q;
   logic [CW-1:0]     phase_last;
   logic              phase_end;

   logic [3:0]        pulse_q;
   logic [3:0]        pulse_dec;

   logic [CW-1:0]     hb_cnt_q;
   logic              hb_led_q;

   logic [NREQ-1:0]   grant_q;
   logic [NREQ-1:0]   grant_d;
   logic              done_q;
   logic              done_d;

   logic              arb_any;
   logic [NREQ-1:0]   arb_onehot;
   logic [3:0]        arb_code;
   logic              start;

   // ---------------------------------------------------------------------------
   // Fixed-priority arbiter. The loop scans from the top index down, so the
   // last match, which wins, is the lowest set index.
   // ---------------------------------------------------------------------------
   always_comb begin
      arb_onehot = '0;
      arb_code   = 4'd0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (REQ[i]) begin
            arb_onehot    = '0;
            arb_onehot[i] = 1'b1;
            arb_code      = CODE[4*i +: 4];
         end
      end
   end

   assign arb_any = |REQ;
   assign start   = (state_q == S_IDLE) && arb_any;

   // ---------------------------------------------------------------------------
   // Phase bookkeeping
   // ---------------------------------------------------------------------------
   assign tick      = (presc_q == PRESC_LAST);
   assign pulse_dec = pulse_q - 4'd1;

   always_comb begin
      phase_last = '0;
      case (state_q)
         S_ON:    phase_last = ON_LAST;
         S_OFF:   phase_last = OFF_LAST;
         S_GAP:   phase_last = GAP_LAST;
         default: phase_last = '0;
      endcase
   end

   assign phase_end = tick && (state_q != S_IDLE) && (phase_q == phase_last);

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            // A zero-length code still owns the LED for one dark gap.
            if (arb_any) begin
               state_d = (arb_code != 4'd0) ? S_ON : S_GAP;
            end
         end
         S_ON: begin
            if (phase_end) begin
               state_d = (pulse_dec != 4'd0) ? S_OFF : S_GAP;
            end
         end
         S_OFF: begin
            if (phase_end) begin
               state_d = S_ON;
            end
         end
         S_GAP: begin
            if (phase_end) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      grant_d = grant_q;
      done_d  = 1'b0;
      if (start) begin
         grant_d = arb_onehot;
      end else if ((state_q == S_GAP) && phase_end) begin
         grant_d = '0;
         done_d  = 1'b1;
      end
   end

   // The LED is decoded from registered state. HB_EN gates the idle heartbeat
   // directly, so clearing HB_EN darkens the LED at once.
   assign LED       = (state_q == S_ON) ||
                      ((state_q == S_IDLE) && HB_EN && hb_led_q);
   assign BUSY      = (state_q != S_IDLE);
   assign GRANT     = grant_q;
   assign DONE      = done_q;
   assign DBG_STATE = state_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         grant_q <= '0;
         done_q  <= 1'b0;
      end else begin
         grant_q <= grant_d;
         done_q  <= done_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Prescaler. It runs freely, but it is re-aligned when a code starts so
   // that every phase lasts an exact multiple of TICKDIV clocks.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         presc_q <= '0;
      end else if (start || tick) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_q + PRESC_ONE;
      end
   end

   // ---------------------------------------------------------------------------
   // Phase counter. It counts ticks within the current state. Every phase end
   // is also a state change, and the counter restarts on any state change.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         phase_q <= '0;
      end else if (state_d != state_q) begin
         phase_q <= '0;
      end else if (tick && (state_q != S_IDLE)) begin
         phase_q <= phase_q + CNT_ONE;
      end
   end

   // ---------------------------------------------------------------------------
   // Pulse counter. It holds the pulses remaining, including the one being lit.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pulse_q <= 4'd0;
      end else if (start) begin
         pulse_q <= arb_code;
      end else if ((state_q == S_ON) && phase_end) begin
         pulse_q <= pulse_dec;
      end
   end

   // ---------------------------------------------------------------------------
   // Heartbeat. It is active only while idle with HB_EN set. Leaving IDLE or
   // clearing HB_EN restarts it dark with a fresh count.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         hb_cnt_q <= '0;
         hb_led_q <= 1'b0;
      end else if ((state_q != S_IDLE) || arb_any || !HB_EN) begin
         hb_cnt_q <= '0;
         hb_led_q <= 1'b0;
      end else if (tick) begin
         if (hb_cnt_q == HB_LAST) begin
            hb_cnt_q <= '0;
            hb_led_q <= ~hb_led_q;
         end else begin
            hb_cnt_q <= hb_cnt_q + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_led_code_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_code_sequencer
//
// Reference model: each granted code is expanded into its LED waveform, one
// bit per clock, held in a queue built from the pulse/gap rules. The model
// pops one entry per clock, and GRANT/BUSY fall with DONE when the queue
// empties. The idle heartbeat is modelled by counting clocks since the last
// prescaler alignment (reset or grant), with a tick every TICKDIV clocks.
// -----------------------------------------------------------------------------
module tb_led_code_sequencer;

   localparam int CLKFREQ = 100;
   localparam int TICK_HZ = 10;
   localparam int NREQ    = 4;
   localparam int ON_T    = 2;
   localparam int OFF_T   = 3;
   localparam int GAP_T   = 10;
   localparam int HB_T    = 5;
   localparam int TD      = CLKFREQ / TICK_HZ;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic              CLK = 1'b0;
   logic              RESET;
   logic [NREQ-1:0]   REQ;
   logic [4*NREQ-1:0] CODE;
   logic              HB_EN;
   logic [NREQ-1:0]   GRANT;
   logic              BUSY;
   logic              DONE;
   logic              LED;
   logic [1:0]        DBG_STATE;

   always #5 CLK = ~CLK;

   led_code_sequencer #(
      .CLKFREQ   (CLKFREQ),
      .TICK_HZ   (TICK_HZ),
      .NREQ      (NREQ),
      .ON_TICKS  (ON_T),
      .OFF_TICKS (OFF_T),
      .GAP_TICKS (GAP_T),
      .HB_TICKS  (HB_T)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .REQ       (REQ),
      .CODE      (CODE),
      .HB_EN     (HB_EN),
      .GRANT     (GRANT),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .LED       (LED),
      .DBG_STATE (DBG_STATE)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   logic chk_en = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected length in clocks of an n-pulse code, from the timing rule.
   function automatic int code_len(input int n);
      if (n == 0) return GAP_T * TD;
      return (n * ON_T + (n - 1) * OFF_T + GAP_T) * TD;
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model / scoreboard
   // ---------------------------------------------------------------------------
   logic [0:0]      exp_q[$];
   logic            m_busy   = 1'b0;
   logic [NREQ-1:0] m_grant  = '0;
   logic            m_done   = 1'b0;
   logic            m_hb_led = 1'b0;
   int              m_hb_cnt = 0;
   int              m_align  = 0;

   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         exp_q.delete();
         m_busy   = 1'b0;
         m_grant  = '0;
         m_done   = 1'b0;
         m_hb_led = 1'b0;
         m_hb_cnt = 0;
         m_align  = 0;
      end else begin
         m_align  = m_align + 1;
         m_done   = 1'b0;
         if (m_busy) begin
            void'(exp_q.pop_front());
            m_hb_led = 1'b0;
            m_hb_cnt = 0;
            if (exp_q.size() == 0) begin
               m_busy  = 1'b0;
               m_grant = '0;
               m_done  = 1'b1;
            end
         end else if (REQ != '0) begin
            int idx;
            int n;
            idx = 0;
            for (int i = NREQ - 1; i >= 0; i--) if (REQ[i]) idx = i;
            n = int'(CODE[4*idx +: 4]);
            for (int p = 0; p < n; p++) begin
               repeat (ON_T * TD) exp_q.push_back(1'b1);
               if (p < n - 1) repeat (OFF_T * TD) exp_q.push_back(1'b0);
            end
            repeat (GAP_T * TD) exp_q.push_back(1'b0);
            m_grant      = '0;
            m_grant[idx] = 1'b1;
            m_busy       = 1'b1;
            m_align      = 0;
            m_hb_led     = 1'b0;
            m_hb_cnt     = 0;
         end else if (!HB_EN) begin
            m_hb_led = 1'b0;
            m_hb_cnt = 0;
         end else if (m_align % TD == 0) begin
            m_hb_cnt = m_hb_cnt + 1;
            if (m_hb_cnt == HB_T) begin
               m_hb_led = ~m_hb_led;
               m_hb_cnt = 0;
            end
         end
      end
   end

   // Per-cycle comparison, sampled away from the active edge.
   always @(negedge CLK) begin
      if (chk_en) begin
         logic exp_led;
         exp_led = m_busy ? exp_q[0] : (m_hb_led & HB_EN);
         check_val("led",   LED,   exp_led);
         check_val("grant", GRANT, m_grant);
         check_val("busy",  BUSY,  m_busy);
         check_val("done",  DONE,  m_done);
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks (inputs change 1 time unit after the rising edge)
   // ---------------------------------------------------------------------------
   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wait_grant(input int budget, output int at);
      bit seen;
      seen = 1'b0;
      at   = 0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge CLK);
         if (GRANT != '0) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
      if (!seen) check_val("grant_timeout", 32'd0, 32'd1);
      step(1);
   endtask

   task automatic wait_done(input int budget, output int at);
      bit seen;
      seen = 1'b0;
      at   = 0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge CLK);
         if (DONE) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
      if (!seen) check_val("done_timeout", 32'd0, 32'd1);
      step(1);
   endtask

   task automatic wait_led_edge(input int budget, output int at);
      bit   seen;
      logic prev;
      seen = 1'b0;
      at   = 0;
      @(negedge CLK);
      prev = LED;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge CLK);
         if (LED !== prev) begin
            seen = 1'b1;
            at   = cyc;
         end
      end
      if (!seen) check_val("hb_timeout", 32'd0, 32'd1);
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int g;
      int d;
      int g2;
      int t1;
      int t2;

      RESET = 1'b1;
      REQ   = '0;
      CODE  = '0;
      HB_EN = 1'b0;
      chk_en = 1'b1;
      step(3);
      check_val("rst_led",   LED,   32'd0);
      check_val("rst_grant", GRANT, 32'd0);
      check_val("rst_busy",  BUSY,  32'd0);
      check_val("rst_done",  DONE,  32'd0);
      RESET = 1'b0;
      step(2);

      // Single request, 3 pulses.
      CODE = 16'h0003;
      REQ  = 4'b0001;
      wait_grant(5, g);
      REQ  = '0;
      wait_done(400, d);
      check_val("single_len", d - g, code_len(3));

      // Priority: requesters 1 and 3 together.
      CODE = 16'h2010;
      REQ  = 4'b1010;
      wait_grant(5, g);
      check_val("prio_first", GRANT, 32'b0010);
      REQ  = 4'b1000;
      wait_done(400, d);
      check_val("prio_len1", d - g, code_len(1));
      wait_grant(5, g2);
      check_val("prio_idle_gap", g2 - d, 32'd1);
      check_val("prio_second", GRANT, 32'b1000);
      REQ  = '0;
      wait_done(400, d);
      check_val("prio_len2", d - g2, code_len(2));

      // Zero-length code.
      CODE = 16'h0000;
      REQ  = 4'b0100;
      wait_grant(5, g);
      REQ  = '0;
      wait_done(400, d);
      check_val("zero_len", d - g, code_len(0));

      // REQ drop and CODE change during the first ON phase.
      CODE = 16'h0003;
      REQ  = 4'b0001;
      wait_grant(5, g);
      step(5);
      REQ  = '0;
      CODE = 16'h0007;
      wait_done(400, d);
      check_val("midchg_len", d - g, code_len(3));

      // Heartbeat while idle, then a code on top of it, then disabled.
      HB_EN = 1'b1;
      wait_led_edge(200, t1);
      wait_led_edge(200, t2);
      check_val("hb_period", t2 - t1, HB_T * TD);
      step(1);
      CODE = 16'h0002;
      REQ  = 4'b0001;
      wait_grant(5, g);
      REQ  = '0;
      wait_done(400, d);
      check_val("hb_code_len", d - g, code_len(2));
      step(80);
      HB_EN = 1'b0;
      step(120);

      // Asynchronous reset in the OFF phase with REQ held.
      CODE = 16'h0003;
      REQ  = 4'b0001;
      wait_grant(5, g);
      step(25);
      RESET = 1'b1;
      #1;
      check_val("arst_led",   LED,   32'd0);
      check_val("arst_grant", GRANT, 32'd0);
      check_val("arst_busy",  BUSY,  32'd0);
      check_val("arst_done",  DONE,  32'd0);
      step(3);
      RESET = 1'b0;
      wait_grant(5, g);
      REQ  = '0;
      wait_done(400, d);
      check_val("arst_restart_len", d - g, code_len(3));

      // Randomized traffic, heartbeat toggling and occasional resets.
      for (int it = 0; it < 40; it++) begin
         REQ   = 4'($urandom_range(0, 15));
         CODE  = 16'($urandom);
         HB_EN = 1'($urandom_range(0, 1));
         step($urandom_range(1, 300));
         if ($urandom_range(0, 9) == 0) begin
            RESET = 1'b1;
            step($urandom_range(1, 3));
            RESET = 1'b0;
         end
      end
      REQ = '0;
      step(900);

      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule

// File: doc/led_code_sequencer.md
Name: led_code_sequencer

Overview:
- Shares the single board status LED between NREQ requesters (capture, FIFO, config, fault, ...).
- Each requester asks for an N-pulse blink code.
- A fixed-priority arbiter grants one requester at a time; a tick-driven FSM plays ON/OFF pulses followed by an inter-code gap.
- With no request pending, the LED shows an optional heartbeat. This block replaces direct LED drivers at the top level.

Parameters:
- CLKFREQ, 25000000, input clock frequency in Hz.
- TICK_HZ, 10, sequencer tick rate. TICKDIV = CLKFREQ/TICK_HZ clocks per tick, integer, >= 2.
- NREQ, 4, number of requesters, 1..8.
- ON_TICKS, 2, ticks the LED is lit per pulse, >= 1.
- OFF_TICKS, 3, ticks dark between pulses within one code, >= 1.
- GAP_TICKS, 10, ticks dark after the last pulse of a code, >= 1.
- HB_TICKS, 5, heartbeat half-period in ticks, >= 1.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- REQ  in  NREQ  level request, bit i = requester i.
- CODE  in  4*NREQ  pulse count for requester i, in bits [4i+3:4i]; 0..15.
- HB_EN  in  1  enable heartbeat blinking while idle.
- GRANT  out  NREQ  one-hot owner of the LED; all zero when idle.
- BUSY  out  1  high whenever a code is in progress (state != IDLE).
- DONE  out  1  one-cycle pulse when a granted code finishes.
- LED  out  1  LED drive, 1 = lit.

Behaviour:
- Reset (async, active-high):
  - state = IDLE, GRANT = 0, BUSY = 0, DONE = 0, LED = 0.
  - Prescaler = 0, phase counter = 0, pulse counter = 0, heartbeat counter = 0.
- Prescaler:
  - Counts 0..TICKDIV-1 and asserts internal TICK on the TICKDIV-1 count, then wraps to 0.
  - Cleared to 0 on the IDLE->ON and IDLE->GAP transitions, so phase durations are exact multiples of TICKDIV.
- States: IDLE, ON, OFF, GAP.
- IDLE:
  - If any REQ bit is set, on the next edge grant the lowest set index i.
  - GRANT becomes one-hot i, BUSY = 1, and CODE[i] is latched into the pulse counter.
  - If latched CODE != 0: go to ON with LED = 1.
  - If latched CODE == 0: go to GAP with LED = 0.
  - Phase counter is cleared on either transition.
- ON:
  - LED = 1. Phase counter increments on TICK.
  - When ON_TICKS TICKs have elapsed: pulse counter decrements.
  - If the decremented value is nonzero: go to OFF. If zero: go to GAP. LED = 0 in both cases.
- OFF:
  - LED = 0. After OFF_TICKS TICKs: go to ON with LED = 1.
- GAP:
  - LED = 0. After GAP_TICKS TICKs, in the same edge: go to IDLE, GRANT = 0, BUSY = 0, DONE = 1 for exactly one cycle.
  - A REQ still pending is arbitrated on the following edge. There is therefore one IDLE cycle minimum between codes.
- Latching and REQ behaviour:
  - REQ/CODE changes during a code are ignored. The latched count plays to completion; there is no abort.
  - A requester that drops REQ mid-code still gets its full code and DONE.
- Heartbeat:
  - Only in IDLE with HB_EN = 1: LED toggles every HB_TICKS ticks, using the free-running prescaler.
  - With HB_EN = 0 in IDLE: LED = 0 and the heartbeat counter is held at 0.
  - On leaving IDLE the heartbeat counter is cleared.
- Code timing: total length of a code of N >= 1 pulses in clocks is (N*ON_TICKS + (N-1)*OFF_TICKS + GAP_TICKS)*TICKDIV.
- Widths:
  - Prescaler uses clog2(TICKDIV) bits.
  - Phase counter is wide enough for max(ON_TICKS, OFF_TICKS, GAP_TICKS, HB_TICKS).
  - All counters are unsigned, and no counter wraps except the prescaler.
- Reset mid-code: immediate return to reset state; no DONE is issued.

Test Plan:
- Bench parameters: CLKFREQ=100, TICK_HZ=10 (TICKDIV=10), ON 2, OFF 3, GAP 10, HB 5.
- Single request: REQ=0001, CODE0=3 -> GRANT=0001 one cycle later. LED high 20 clks, low 30, high 20, low 30, high 20, low 100. DONE pulses at clk 220 after grant. GRANT/BUSY drop with DONE.
- Priority: REQ=1010 asserted together, CODE1=1, CODE3=2 -> requester 1 served first (LED 20 on / 100 off, DONE). Then after one IDLE cycle GRANT=1000 plays 2 pulses.
- CODE=0: REQ=0100, CODE2=0 -> GRANT=0100, LED stays 0, DONE after 100 clocks.
- Request drop and CODE change mid-code: REQ0 deasserted and CODE0 changed to 7 during the first ON -> original 3-pulse code completes unchanged, DONE asserted.
- Heartbeat: HB_EN=1, REQ=0 -> LED toggles every 50 clks. Asserting REQ forces the code pattern. With HB_EN=0, LED is constant 0 in idle.
- Async reset: assert RESET during OFF of a code -> LED, GRANT, BUSY, DONE go 0 without waiting for a CLK edge. No DONE is issued. After release with REQ held, the code restarts from its first pulse.
